mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences every load/store of the MEM stage onto the data SRAM-like bus (req/addr_ok/data_ok).
//  Generates the MEM-stage stall, extracts and extends load data, and replicates store data.
//  Flags misaligned addresses without a bus access.
//  Keeps bus protocol integrity across pipeline flushes by draining a cancelled transaction.
//  Sits between the EX/MEM boundary registers and the data-side bus; its stall drives mem_stall_o.
// PARAMETERS
//  AW   32  data address width
//  DW   32  data bus width (fixed 32; byte lanes = DW/8)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  acc_valid_i    in   1   instruction present at MEM input
//  acc_memop_i    in   4   `MMOP code: NOP,LB,LBU,LH,LHU,LW,SB,SH,SW
//  acc_addr_i     in   AW  effective address
//  acc_sdata_i    in   DW  store source register value
//  pipe_stall_i   in   1   downstream stall (WB cannot accept)
//  pipe_flush_i   in   1   flush of MEM and younger
//  data_req_o     out  1   bus request
//  data_wr_o      out  1   1=store
//  data_size_o    out  2   0=byte,1=half,2=word
//  data_addr_o    out  AW  bus address (unaligned byte address as issued)
//  data_wdata_o   out  DW  lane-replicated store data
//  data_addr_ok_i in   1   address accepted
//  data_data_ok_i in   1   data phase complete (rdata valid on loads)
//  data_rdata_i   in   DW  raw read word
//  ld_data_o      out  DW  extended load result, valid in DONE
//  stall_o        out  1   hold MEM input and older stages
//  exc_adel_o     out  1   misaligned load
//  exc_ades_o     out  1   misaligned store
// BEHAVIOUR
//  States: IDLE, REQ, WAIT, DONE, CANCEL.
//  Reset: state=IDLE; data_req_o=0; data_wr_o=0; data_size_o=0; data_addr_o=0; data_wdata_o=0;
//   ld_data_o=0; stall_o=0; exc_*=0.
//  go = acc_valid_i & memop!=NOP & ~misaligned & ~pipe_flush_i.
//  misaligned: H ops addr[0]!=0; W ops addr[1:0]!=0. Comb exc_adel_o/exc_ades_o=acc_valid_i&~flush&misaligned.
//   No bus access on misalignment; stall_o=0.
//  IDLE:
//   go -> REQ; latch wr, size, addr, wdata, op, addr[1:0].
//   stall_o=1 comb in the accept cycle.
//  REQ:
//   data_req_o=1 (registered); all bus outputs stable until addr_ok.
//   addr_ok -> WAIT; addr_ok & data_ok same cycle -> DONE.
//   flush -> keep req; addr_ok -> CANCEL.
//  WAIT:
//   data_ok -> DONE; capture ld_data_o.
//   flush -> CANCEL; flush & data_ok same cycle -> IDLE.
//  DONE:
//   stall_o=0; ld_data_o held.
//   ~pipe_stall_i | pipe_flush_i -> IDLE.
//   Never reissues for the held instruction.
//  CANCEL:
//   discard data; data_ok -> IDLE.
//   stall_o = acc_valid_i & memop!=NOP (new access waits).
//  stall_o=1 in REQ and WAIT unless pipe_flush_i.
//  Minimum access latency: accept -> DONE = 2 cycles with zero-wait bus.
//  Only one outstanding transaction.
//  Load extract by latched addr[1:0]: byte lane = addr*8; half lane = addr[1]*16.
//   LB/LH sign-extend; LBU/LHU zero-extend; LW raw.
//  Store: SB wdata={4{b}}; SH {2{h}}; SW raw.
//  Reset mid-transaction: return to IDLE immediately; bus drain is not owned here.
// STRUCTURE
//  `MMOP codes and size encodings go in defines.v (shared).
//  Sub-module load_align: combinational op + addr[1:0] + rdata -> ld_data.
//  FSM and bus registers live in the top module; DFFRE-style regs with en.
// TESTING
//  1 LW addr 0x100, bus addr_ok+data_ok next cycle, rdata=0xDEADBEEF:
//    stall 2 cycles, ld_data=0xDEADBEEF.
//  2 LB addr 0x103 rdata=0x80112233 -> ld_data=0xFFFFFF80; LBU -> 0x00000080.
//    LH 0x102 -> 0xFFFF8011.
//  3 SH addr 0x202 data 0x1234ABCD:
//    data_wdata=0xABCDABCD, size=1, wr=1; no ld_data update.
//  4 LW addr 0x101:
//    exc_adel_o=1 same cycle, data_req never asserted, stall_o=0.
//  5 Flush while REQ with addr_ok delayed 3 cycles:
//    req held until addr_ok, CANCEL, data_ok discarded, next LW issues only after drain.
//  6 pipe_stall_i=1 for 4 cycles in DONE:
//    stays DONE, ld_data stable, exactly one bus request observed.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - memory-op codes, bus size encodings, FSM states and op helpers
package mem_access_ctrl_pkg;

  localparam logic [3:0] MMOP_NOP = 4'd0;
  localparam logic [3:0] MMOP_LB  = 4'd1;
  localparam logic [3:0] MMOP_LBU = 4'd2;
  localparam logic [3:0] MMOP_LH  = 4'd3;
  localparam logic [3:0] MMOP_LHU = 4'd4;
  localparam logic [3:0] MMOP_LW  = 4'd5;
  localparam logic [3:0] MMOP_SB  = 4'd6;
  localparam logic [3:0] MMOP_SH  = 4'd7;
  localparam logic [3:0] MMOP_SW  = 4'd8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_CANCEL
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return op inside {MMOP_LB, MMOP_LBU, MMOP_LH, MMOP_LHU, MMOP_LW};
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op inside {MMOP_SB, MMOP_SH, MMOP_SW};
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      MMOP_LH, MMOP_LHU, MMOP_SH: return SIZE_HALF;
      MMOP_LW, MMOP_SW:           return SIZE_WORD;
      default:                    return SIZE_BYTE;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
    case (op_size(op))
      SIZE_HALF: return lo[0];
      SIZE_WORD: return lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// rtl/mem_access_ctrl_load_align.sv - picks the addressed lane of a read word and extends it
module mem_access_ctrl_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MMOP_LB:  ld_data = {{24{byte_lane[7]}}, byte_lane};
      MMOP_LBU: ld_data = {24'b0, byte_lane};
      MMOP_LH:  ld_data = {{16{half_lane[15]}}, half_lane};
      MMOP_LHU: ld_data = {16'b0, half_lane};
      default:  ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer for the req/addr_ok/data_ok data bus
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_valid_i,
  input  logic [3:0]    acc_memop_i,
  input  logic [AW-1:0] acc_addr_i,
  input  logic [DW-1:0] acc_sdata_i,
  input  logic          pipe_stall_i,
  input  logic          pipe_flush_i,
  output logic          data_req_o,
  output logic          data_wr_o,
  output logic [1:0]    data_size_o,
  output logic [AW-1:0] data_addr_o,
  output logic [DW-1:0] data_wdata_o,
  input  logic          data_addr_ok_i,
  input  logic          data_data_ok_i,
  input  logic [DW-1:0] data_rdata_i,
  output logic [DW-1:0] ld_data_o,
  output logic          stall_o,
  output logic          exc_adel_o,
  output logic          exc_ades_o
);

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic          cancel_q;
  logic          is_mem, misaligned, go, accept, capture;
  logic [DW-1:0] sdata_rep, ld_ext;

  mem_access_ctrl_load_align u_load_align (
    .op      (op_q),
    .off     (off_q),
    .rdata   (data_rdata_i),
    .ld_data (ld_ext)
  );

  always_comb begin
    is_mem     = acc_valid_i && (op_is_load(acc_memop_i) || op_is_store(acc_memop_i));
    misaligned = is_mem && op_misaligned(acc_memop_i, acc_addr_i[1:0]);
    go         = is_mem && !misaligned && !pipe_flush_i;
    exc_adel_o = misaligned && !pipe_flush_i && op_is_load(acc_memop_i);
    exc_ades_o = misaligned && !pipe_flush_i && op_is_store(acc_memop_i);
    case (op_size(acc_memop_i))
      SIZE_BYTE: sdata_rep = {4{acc_sdata_i[7:0]}};
      SIZE_HALF: sdata_rep = {2{acc_sdata_i[15:0]}};
      default:   sdata_rep = acc_sdata_i;
    endcase
  end

  // A flush seen while the address is still pending is remembered in cancel_q,
  // so the request is held to completion and the response drained afterwards.
  always_comb begin
    state_nx = state;
    stall_o  = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          accept   = 1'b1;
          stall_o  = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_o = cancel_q ? is_mem : !pipe_flush_i;
        if (data_addr_ok_i) begin
          if (cancel_q || pipe_flush_i) begin
            state_nx = data_data_ok_i ? ST_IDLE : ST_CANCEL;
          end else if (data_data_ok_i) begin
            capture  = 1'b1;
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_o = !pipe_flush_i;
        if (pipe_flush_i) begin
          state_nx = data_data_ok_i ? ST_IDLE : ST_CANCEL;
        end else if (data_data_ok_i) begin
          capture  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!pipe_stall_i || pipe_flush_i) state_nx = ST_IDLE;
      end
      ST_CANCEL: begin
        stall_o = is_mem;
        if (data_data_ok_i) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      data_req_o   <= 1'b0;
      data_wr_o    <= 1'b0;
      data_size_o  <= SIZE_BYTE;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      op_q         <= MMOP_NOP;
      off_q        <= 2'b00;
      cancel_q     <= 1'b0;
      ld_data_o    <= '0;
    end else begin
      state    <= state_nx;
      cancel_q <= (state == ST_REQ) && !data_addr_ok_i && (cancel_q || pipe_flush_i);
      if (accept) begin
        data_req_o   <= 1'b1;
        data_wr_o    <= op_is_store(acc_memop_i);
        data_size_o  <= op_size(acc_memop_i);
        data_addr_o  <= acc_addr_i;
        data_wdata_o <= sdata_rep;
        op_q         <= acc_memop_i;
        off_q        <= acc_addr_i[1:0];
      end else if (state == ST_REQ && data_addr_ok_i) begin
        data_req_o <= 1'b0;
      end
      if (capture && op_is_load(op_q)) ld_data_o <= ld_ext;
    end
  end

endmodule
